memory_read_unit: RTL
=====================

// Module: memory_read_unit
// PURPOSE
//   Load path of the rv32i data-memory interface, mirror of the store-side byte-lane replicator.
//   Accepts a load request (byte address, access size, signedness) and issues one word-aligned read to data memory.
//   Then extracts the addressed byte/half/word lane, sign- or zero-extends it and holds the result until consumed.
//   Sits between the core's memory stage and the synchronous data memory.
// PARAMETERS
//   L  128  memory size in bytes; address width is $clog2(L)
//   W  32   data width; only 32 supported, other values -> $display error + $finish at elaboration
// PORTS
//   clk           in   1               clock; all state on rising edge
//   rst           in   1               reset, asynchronous, active-high
//   req_valid     in   1               load request present
//   req_ready     out  1               unit can accept a request this cycle
//   req_addr      in   $clog2(L)       byte address
//   req_access    in   mem_access_t    MEM_ACCESS_BYTE / _HALF / _WORD
//   req_unsigned  in   1               1 = zero-extend (LBU/LHU), 0 = sign-extend
//   mem_rd_en     out  1               one-cycle read strobe to memory
//   mem_rd_addr   out  $clog2(L)       word-aligned address, low 2 bits forced 0
//   mem_rd_valid  in   1               memory read data valid (any latency >= 1 cycle)
//   mem_rd_data   in   W               raw memory word
//   rsp_valid     out  1               extended load result available
//   rsp_ready     in   1               consumer takes the result
//   rsp_data      out  W               extended load result
//   rsp_misaligned out 1               only with MEM_READ_MISALIGN_CHECK_EN; misaligned access flag
// BEHAVIOUR
//   - Reset (async, immediate): state IDLE; rsp_valid=0, rsp_data=0, rsp_misaligned=0; latched request fields cleared.
//   - States: IDLE -> WAIT -> RESP -> IDLE.
//   - req_ready = (state==IDLE) || (state==RESP && rsp_ready).
//   - Accept on req_valid && req_ready: latch addr[1:0], access, unsigned.
//     mem_rd_en = req_valid && req_ready (combinational); mem_rd_addr = {req_addr[hi:2],2'b00}; next state WAIT.
//   - WAIT: on mem_rd_valid, register the extracted result into rsp_data, next state RESP.
//     Latency: memory data at cycle k -> rsp_valid at k+1.
//   - RESP: rsp_valid=1, rsp_data stable until rsp_ready.
//     rsp_ready with no new request -> IDLE; rsp_ready with a new request -> accept it, go to WAIT (back-to-back).
//   - mem_rd_valid in IDLE/RESP is ignored. A response still in flight at reset is therefore dropped.
//   - Extraction, off = latched addr[1:0]:
//     BYTE: lane = mem_rd_data[8*off +: 8].
//     HALF: lane = mem_rd_data[16*off[1] +: 16]; off[0] ignored.
//     WORD: full word; off ignored.
//     Illegal access encoding: rsp_data = 0.
//   - Extension: BYTE/HALF sign-extended from bit 7/15 unless unsigned; WORD ignores req_unsigned.
// CONFIGURATION
//   MEM_READ_MISALIGN_CHECK_EN defined:
//     - HALF with off[0]=1, or WORD with off!=0, is misaligned.
//     - On acceptance, no mem_rd_en is issued; next state RESP directly with rsp_data=0, rsp_misaligned=1.
//     - rsp_misaligned=0 for aligned accesses.
//   Not defined: rsp_misaligned port absent; misaligned accesses round down as in the extraction rules.
// STRUCTURE
//   - Package memory_access.sv (existing): mem_access_t. Add to it:
//     MEM_BYTE_OFFSET_W = 2 and a state enum mem_rd_state_t {MEM_RD_IDLE, MEM_RD_WAIT, MEM_RD_RESP}.
//   - Sub-module memory_read_byte_extractor: combinational lane select + extension (offset, access, unsigned, word -> W).
//     memory_read_unit holds FSM, latches and output register.
// TESTING
//   1 LB addr=0x13, unsigned=0, mem word 0x80_7F_12_34 -> mem_rd_addr=0x10; rsp_data=0xFFFFFF80 one cycle after mem_rd_valid.
//   2 LHU addr=0x22, mem word 0xBEEF_1234 -> rsp_data=0x0000BEEF; LH same -> 0xFFFFBEEF.
//   3 LW addr=0x04, word 0xDEADBEEF, rsp_ready held low 3 cycles -> rsp_valid, rsp_data stable; req_ready=0 during hold.
//   4 Back-to-back: LB then LBU in RESP with rsp_ready=1 -> second accepted that cycle, mem_rd_en pulses, no idle gap.
//   5 rst asserted in WAIT, mem_rd_valid arrives after release -> IDLE, rsp_valid stays 0, response ignored.
//   6 (MEM_READ_MISALIGN_CHECK_EN) LW addr=0x05 -> no mem_rd_en, next cycle rsp_valid=1, rsp_misaligned=1, rsp_data=0.
//     Without the macro -> reads word 0x04.

Source files
------------

// File: rtl/memory_access.sv
// Shared types for the rv32i data-memory load/store path.
// Latency: n/a (types, constants and one pure helper only).
// Backpressure: n/a.
//
// Contents: mem_access_t (access size), MEM_BYTE_OFFSET_W (byte-in-word offset width),
// mem_rd_state_t (load FSM states), mem_is_misaligned() helper.
package memory_access;

   typedef enum logic [1:0] {
      MEM_ACCESS_BYTE = 2'b00,
      MEM_ACCESS_HALF = 2'b01,
      MEM_ACCESS_WORD = 2'b10
   } mem_access_t;

   localparam int MEM_BYTE_OFFSET_W = 2;

   typedef enum logic [1:0] {
      MEM_RD_IDLE,
      MEM_RD_WAIT,
      MEM_RD_RESP
   } mem_rd_state_t;

   // Half on an odd byte, or word on any non-zero offset, straddles a lane boundary.
   function automatic logic mem_is_misaligned(input logic [MEM_BYTE_OFFSET_W-1:0] offset,
                                              input mem_access_t access);
      logic mis;
      mis = 1'b0;
      case (access)
         MEM_ACCESS_HALF: mis = offset[0];
         MEM_ACCESS_WORD: mis = (offset != '0);
         default:         mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/memory_read_byte_extractor.sv
// Selects the addressed byte/half/word lane of a memory word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none (no handshake).
//
// Ports: offset      byte offset within the word (half uses bit 1 only, word ignores it)
//        access      byte / half / word; any other encoding yields zero
//        is_unsigned 1 = zero-extend byte/half, 0 = sign-extend; ignored for word
//        word        raw memory word
//        data        extended result
module memory_read_byte_extractor
   import memory_access::*;
#(
   parameter int W = 32
) (
   input  logic [MEM_BYTE_OFFSET_W-1:0] offset,
   input  mem_access_t                  access,
   input  logic                         is_unsigned,
   input  logic [W-1:0]                 word,
   output logic [W-1:0]                 data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic        byte_sign;
   logic        half_sign;

   always_comb begin
      byte_lane = word[7:0];
      case (offset)
         2'd0:    byte_lane = word[7:0];
         2'd1:    byte_lane = word[15:8];
         2'd2:    byte_lane = word[23:16];
         default: byte_lane = word[31:24];
      endcase
      half_lane = offset[1] ? word[31:16] : word[15:0];
   end

   assign byte_sign = ~is_unsigned & byte_lane[7];
   assign half_sign = ~is_unsigned & half_lane[15];

   always_comb begin
      data = '0;
      case (access)
         MEM_ACCESS_BYTE: data = {{(W-8){byte_sign}}, byte_lane};
         MEM_ACCESS_HALF: data = {{(W-16){half_sign}}, half_lane};
         MEM_ACCESS_WORD: data = word;
         default:         data = '0;
      endcase
   end

endmodule

// File: rtl/memory_read_unit.sv
// Load path: one word-aligned memory read per request, lane extract + extend, result held until taken.
// Latency: request accept -> mem_rd_en same cycle; mem_rd_valid at cycle k -> rsp_valid at k+1.
// Backpressure: req_ready low while a read is outstanding or an unconsumed result is held.
//
// Ports: clk, rst (async, active-high)
//        req_valid/req_ready/req_addr/req_access/req_unsigned   load request
//        mem_rd_en/mem_rd_addr                                  read strobe + word address to memory
//        mem_rd_valid/mem_rd_data                               memory return (any latency >= 1)
//        rsp_valid/rsp_ready/rsp_data                           extended result
//        rsp_misaligned                                         only with MEM_READ_MISALIGN_CHECK_EN
// Optional feature macro: MEM_READ_MISALIGN_CHECK_EN (misaligned half/word answered with an error
// flag and no memory read). Undefined: misaligned accesses round down to the containing lane.
module memory_read_unit
   import memory_access::*;
#(
   parameter int L = 128,
   parameter int W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [$clog2(L)-1:0] req_addr,
   input  mem_access_t          req_access,
   input  logic                 req_unsigned,
   output logic                 mem_rd_en,
   output logic [$clog2(L)-1:0] mem_rd_addr,
   input  logic                 mem_rd_valid,
   input  logic [W-1:0]         mem_rd_data,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [W-1:0]         rsp_data
`ifdef MEM_READ_MISALIGN_CHECK_EN
   ,
   output logic                 rsp_misaligned
`endif
);

   localparam int AW = $clog2(L);

   if (W != 32) begin : g_w_check
      $error("memory_read_unit: only W=32 is supported");
   end

   mem_rd_state_t                state_q;
   mem_rd_state_t                state_d;
   logic [MEM_BYTE_OFFSET_W-1:0] off_q;
   mem_access_t                  access_q;
   logic                         unsigned_q;
   logic [W-1:0]                 rsp_data_q;
   logic [W-1:0]                 extracted;
   logic                         accept;
   logic                         req_mis;

   assign req_ready = (state_q == MEM_RD_IDLE) || ((state_q == MEM_RD_RESP) && rsp_ready);
   assign accept    = req_valid && req_ready;

`ifdef MEM_READ_MISALIGN_CHECK_EN
   assign req_mis = mem_is_misaligned(req_addr[MEM_BYTE_OFFSET_W-1:0], req_access);
`else
   assign req_mis = 1'b0;
`endif

   // A misaligned request never touches memory; it is answered straight from RESP.
   assign mem_rd_en   = accept && !req_mis;
   assign mem_rd_addr = {req_addr[AW-1:MEM_BYTE_OFFSET_W], {MEM_BYTE_OFFSET_W{1'b0}}};

   assign rsp_valid = (state_q == MEM_RD_RESP);
   assign rsp_data  = rsp_data_q;

   // Extraction works on the latched request fields, since req_* may change while WAIT.
   memory_read_byte_extractor #(.W(W)) u_extract (
      .offset      (off_q),
      .access      (access_q),
      .is_unsigned (unsigned_q),
      .word        (mem_rd_data),
      .data        (extracted)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         MEM_RD_IDLE: begin
            if (accept) state_d = req_mis ? MEM_RD_RESP : MEM_RD_WAIT;
         end
         MEM_RD_WAIT: begin
            if (mem_rd_valid) state_d = MEM_RD_RESP;
         end
         MEM_RD_RESP: begin
            // Consumption and a new acceptance can share a cycle (back-to-back).
            if (rsp_ready) begin
               if (accept) state_d = req_mis ? MEM_RD_RESP : MEM_RD_WAIT;
               else        state_d = MEM_RD_IDLE;
            end
         end
         default: state_d = MEM_RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= MEM_RD_IDLE;
         off_q      <= '0;
         access_q   <= MEM_ACCESS_BYTE;
         unsigned_q <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            off_q      <= req_addr[MEM_BYTE_OFFSET_W-1:0];
            access_q   <= req_access;
            unsigned_q <= req_unsigned;
         end
         // mem_rd_valid outside WAIT is a stale or stray return and is dropped.
         if ((state_q == MEM_RD_WAIT) && mem_rd_valid) begin
            rsp_data_q <= extracted;
         end else if (accept && req_mis) begin
            rsp_data_q <= '0;
         end
      end
   end

`ifdef MEM_READ_MISALIGN_CHECK_EN
   logic mis_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mis_q <= 1'b0;
      end else if (accept) begin
         mis_q <= req_mis;
      end else if ((state_q == MEM_RD_RESP) && rsp_ready) begin
         mis_q <= 1'b0;
      end
   end

   assign rsp_misaligned = mis_q;
`endif

endmodule
